p_mul_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared packed multiplier (`p_mul`). It accepts multiply/carry-less-multiply requests from two independent issue ports. It grants one request at a time by round-robin and holds the multiplier's valid and operands stable for the whole multi-cycle operation. It then returns the result to the owning requester over a valid/ready response channel. It sits between the issue logic (port 0: core, port 1: coprocessor sequencer) and the single `p_mul` instance.

---
 rtl/p_mul_arb_pkg.sv | 39 +++
 rtl/p_mul_arb_rr2.sv | 20 ++
 rtl/p_mul_arb.sv | 154 +++++++++++++++
 tb/tb_p_mul_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_mul_arb_pkg.sv
// Shared constants for the p_mul arbiter: state encoding, pack-width bits, op bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package p_mul_arb_pkg;

  localparam int XLEN = 32;
  localparam int PW_W = 5;

  // One-hot pack-width bit positions
  localparam int PW32_BIT = 0;
  localparam int PW16_BIT = 1;
  localparam int PW8_BIT  = 2;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Operation bundle handed to the multiplier: 3 op bits + pw + two operands
  localparam int OP_W = 3 + PW_W + 2 * XLEN;

  typedef struct packed {
    logic            mul_l;
    logic            mul_h;
    logic            clmul;
    logic [PW_W-1:0] pw;
    logic [XLEN-1:0] crs1;
    logic [XLEN-1:0] crs2;
  } op_t;

  // Legal pack width: exactly one of 32/16/8 selected, upper bits clear
  function automatic logic pw_legal(input logic [PW_W-1:0] pw);
    logic [2:0] w;
    w = pw[PW8_BIT:PW32_BIT];
    return (pw[PW_W-1:3] == 2'b00) &&
           ((w == 3'b001) || (w == 3'b010) || (w == 3'b100));
  endfunction

endpackage

// File: rtl/p_mul_arb_rr2.sv
// Two-way round-robin picker: one-hot grant from request vector and last winner.
// Latency: purely combinational.
// Backpressure: none; the caller masks requests when it cannot accept.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // A single requester wins outright; on a tie the port that did not win last goes
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/p_mul_arb.sv
// Arbitrates two issue ports onto the shared packed multiplier and returns results.
// Latency: accept T, response at T+2+L (L=32/16/8), illegal pw answered at T+1.
// Backpressure: one op in flight; no grant until the owner accepts its response.
module p_mul_arb
  import p_mul_arb_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_mul_l,
  input  logic            req0_mul_h,
  input  logic            req0_clmul,
  input  logic [PW_W-1:0] req0_pw,
  input  logic [XLEN-1:0] req0_crs1,
  input  logic [XLEN-1:0] req0_crs2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_mul_l,
  input  logic            req1_mul_h,
  input  logic            req1_clmul,
  input  logic [PW_W-1:0] req1_pw,
  input  logic [XLEN-1:0] req1_crs1,
  input  logic [XLEN-1:0] req1_crs2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp0_err,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic            rsp1_err,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic            mul_mul_l,
  output logic            mul_mul_h,
  output logic            mul_clmul,
  output logic [PW_W-1:0] mul_pw,
  output logic [XLEN-1:0] mul_crs1,
  output logic [XLEN-1:0] mul_crs2,
  input  logic [XLEN-1:0] mul_result
);

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            is_idle;
  logic [1:0]      req_vld;
  logic [1:0]      grant;
  logic            accept;
  logic            rsp_hs;
  op_t             req0_op, req1_op, sel_op, mul_op;

  assign is_idle = (state_q == ST_IDLE);
  assign req_vld = {req1_valid, req0_valid} & {2{is_idle}};

  rr_arb2 u_rr (
    .req_i   (req_vld),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign req0_op = {req0_mul_l, req0_mul_h, req0_clmul, req0_pw, req0_crs1, req0_crs2};
  assign req1_op = {req1_mul_l, req1_mul_h, req1_clmul, req1_pw, req1_crs1, req1_crs2};
  assign sel_op  = grant[1] ? req1_op : req0_op;

  assign rsp_hs = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // Sequencer: grant in IDLE, hold the op through BUSY, wait for the owner in RESP
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          last_d  = grant[1];
          op_d    = sel_op;
          if (pw_legal(sel_op.pw)) begin
            state_d = ST_BUSY;
          end else begin
            // Illegal width is answered immediately; the multiplier never starts
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (mul_ready) begin
          rsp_data_d = mul_result;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Valid drops in RESP so the multiplier does not restart after its finish pulse
  assign mul_valid = (state_q == ST_BUSY);
  assign mul_op    = is_idle ? '0 : op_q;
  assign mul_mul_l = mul_op.mul_l;
  assign mul_mul_h = mul_op.mul_h;
  assign mul_clmul = mul_op.clmul;
  assign mul_pw    = mul_op.pw;
  assign mul_crs1  = mul_op.crs1;
  assign mul_crs2  = mul_op.crs2;

  // Only the owning port sees the response; the other side reads zero
  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_data  = rsp0_valid ? rsp_data_q : '0;
  assign rsp1_data  = rsp1_valid ? rsp_data_q : '0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_p_mul_arb.sv
// Bench for p_mul_arb: behavioural multiplier on the mul side, scenario tasks on the ports.
// Latency: checks accept-to-response distance against the pack width.
// Backpressure: exercises held-low response ready and contention between ports.
module tb_p_mul_arb;

  logic        clock, resetn;
  logic        req0_valid, req0_ready, req0_mul_l, req0_mul_h, req0_clmul;
  logic [4:0]  req0_pw;
  logic [31:0] req0_crs1, req0_crs2;
  logic        req1_valid, req1_ready, req1_mul_l, req1_mul_h, req1_clmul;
  logic [4:0]  req1_pw;
  logic [31:0] req1_crs1, req1_crs2;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic        mul_valid, mul_ready, mul_mul_l, mul_mul_h, mul_clmul;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1, mul_crs2, mul_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit spur  = 0;

  // per-port stored operands for the contention scenario
  logic        r_l [2];
  logic        r_h [2];
  logic        r_c [2];
  logic [31:0] r_a [2];
  logic [31:0] r_b [2];

  p_mul_arb dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mul_l(req0_mul_l),
    .req0_mul_h(req0_mul_h), .req0_clmul(req0_clmul), .req0_pw(req0_pw),
    .req0_crs1(req0_crs1), .req0_crs2(req0_crs2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mul_l(req1_mul_l),
    .req1_mul_h(req1_mul_h), .req1_clmul(req1_clmul), .req1_pw(req1_pw),
    .req1_crs1(req1_crs1), .req1_crs2(req1_crs2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_mul_l(mul_mul_l), .mul_mul_h(mul_mul_h),
    .mul_clmul(mul_clmul), .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2),
    .mul_result(mul_result)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  function automatic bit legal_pw(input logic [4:0] pw);
    return (pw[4:3] == 2'b00) && ($countones(pw[2:0]) == 1);
  endfunction

  function automatic int lane_w(input logic [4:0] pw);
    return pw[0] ? 32 : (pw[1] ? 16 : 8);
  endfunction

  // Lane-wise reference: low or high half of each lane product, integer or carry-less
  function automatic logic [31:0] pmul_ref(input logic h, input logic c, input logic [4:0] pw,
                                           input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] r;
    logic [63:0] x, y, p, m;
    if (!legal_pw(pw)) return 32'h0;
    w = lane_w(pw);
    m = (64'd1 << w) - 64'd1;
    r = 0;
    for (int k = 0; k < 32 / w; k++) begin
      x = ({32'h0, a} >> (k * w)) & m;
      y = ({32'h0, b} >> (k * w)) & m;
      if (c) begin
        p = 0;
        for (int i = 0; i < w; i++) if (y[i]) p = p ^ (x << i);
      end else begin
        p = x * y;
      end
      if (h) p = p >> w;
      p = p & m;
      r = r | 32'(p << (k * w));
    end
    return r;
  endfunction

  // Behavioural p_mul: finish pulse in the (L+1)th consecutive valid cycle
  initial begin : fake_mul
    int cnt;
    cnt = 0;
    mul_ready = 0;
    mul_result = 0;
    forever begin
      @(negedge clock);
      mul_ready  = 0;
      mul_result = 32'hDEADBEEF;
      if (mul_valid === 1'b1) begin
        cnt++;
        if (cnt == lane_w(mul_pw) + 1) begin
          mul_ready  = 1;
          mul_result = pmul_ref(mul_mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2);
        end
      end else begin
        cnt = 0;
        if (spur) mul_ready = 1;
      end
    end
  end

  task automatic drive(input int port, input logic v, input logic l, input logic h, input logic c,
                       input logic [4:0] pw, input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_mul_l = l; req0_mul_h = h; req0_clmul = c;
      req0_pw = pw; req0_crs1 = a; req0_crs2 = b;
    end else begin
      req1_valid = v; req1_mul_l = l; req1_mul_h = h; req1_clmul = c;
      req1_pw = pw; req1_crs1 = a; req1_crs2 = b;
    end
  endtask

  task automatic apply_reset;
    @(negedge clock);
    resetn = 0;
    repeat (2) @(negedge clock);
    resetn = 1;
  endtask

  // One request on a port, checked for latency, result, multiplier usage and hold behaviour
  task automatic do_req(input int port, input logic l, input logic h, input logic c,
                        input logic [4:0] pw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input int hold, input bit chk_other);
    int t0, lat, nvalid, badops;
    bit got, legal, holdbad;
    logic [31:0] d0;
    legal = legal_pw(pw);
    lat = legal ? lane_w(pw) + 2 : 1;
    if (port == 0) rsp0_ready = (hold == 0); else rsp1_ready = (hold == 0);
    drive(port, 1, l, h, c, pw, a, b);
    #1;
    got = (port == 1) ? req1_ready : req0_ready;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock); #1;
      got = (port == 1) ? req1_ready : req0_ready;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL accept_timeout port%0d: ready=0 want 1", port);
      drive(port, 0, l, h, c, pw, a, b);
      return;
    end
    t0 = cyc;
    @(posedge clock); #1;
    drive(port, 0, l, h, c, pw, a, b);
    if (chk_other) req1_valid = 1;
    nvalid = 0; badops = 0; got = 0; holdbad = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (mul_valid) begin
        nvalid++;
        if ({mul_mul_l, mul_mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2} !== {l, h, c, pw, a, b})
          badops++;
      end
      if (chk_other && req1_ready) holdbad = 1;
      got = (port == 1) ? rsp1_valid : rsp0_valid;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rsp_timeout port%0d: rsp_valid=0 want 1", port);
      return;
    end
    total++;
    if (cyc - t0 != lat) begin
      bad++; $display("FAIL rsp_latency port%0d: got %0d want %0d", port, cyc - t0, lat);
    end
    d0 = (port == 1) ? rsp1_data : rsp0_data;
    total++;
    if (d0 !== exp_d) begin
      bad++; $display("FAIL rsp_data port%0d: got %h want %h", port, d0, exp_d);
    end
    total++;
    if (((port == 1) ? rsp1_err : rsp0_err) !== !legal) begin
      bad++; $display("FAIL rsp_err port%0d: got %b want %b", port,
                      (port == 1) ? rsp1_err : rsp0_err, !legal);
    end
    total++;
    if (((port == 1) ? rsp0_valid : rsp1_valid) !== 1'b0) begin
      bad++; $display("FAIL rsp_other_valid port%0d: got 1 want 0", port);
    end
    total++;
    if (nvalid != (legal ? lane_w(pw) + 1 : 0) || badops != 0) begin
      bad++; $display("FAIL mul_valid_cycles port%0d: got %0d (bad ops %0d) want %0d", port,
                      nvalid, badops, legal ? lane_w(pw) + 1 : 0);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if (((port == 1) ? rsp1_valid : rsp0_valid) !== 1'b1) holdbad = 1;
      if (((port == 1) ? rsp1_data : rsp0_data) !== d0) holdbad = 1;
      if (mul_valid !== 1'b0) holdbad = 1;
      if (chk_other && req1_ready) holdbad = 1;
    end
    total++;
    if (holdbad) begin
      bad++; $display("FAIL rsp_hold port%0d: response/side signals changed while ready low", port);
    end
    if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(negedge clock);
    total++;
    if (((port == 1) ? rsp1_valid : rsp0_valid) !== 1'b0) begin
      bad++; $display("FAIL rsp_release port%0d: valid=1 want 0 after handshake", port);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mul_valid, req0_ready, req1_ready} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000",
                      {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mul_valid, req0_ready, req1_ready});
    end
    total++;
    if ({rsp0_data, rsp1_data} !== 64'h0) begin
      bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp0_data, rsp1_data});
    end
    total++;
    if ({mul_mul_l, mul_mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2} !== 72'h0) begin
      bad++; $display("FAIL reset_mul_ops: got %h want 0", {mul_pw, mul_crs1, mul_crs2});
    end
  endtask

  task automatic rand_port(input int g, input logic v);
    int s;
    s = $urandom_range(0, 2);
    r_l[g] = (s == 0); r_h[g] = (s == 1); r_c[g] = (s == 2);
    r_a[g] = $urandom; r_b[g] = $urandom;
    drive(g, v, r_l[g], r_h[g], r_c[g], 5'b00100, r_a[g], r_b[g]);
  endtask

  // Both ports request pw8 continuously from reset: expect grants 0,1,0,1
  task automatic test_alternate;
    int grants, rsps, g, p;
    logic exp_last;
    logic [31:0] pend [2];
    rsp0_ready = 1; rsp1_ready = 1;
    apply_reset();
    rand_port(0, 1);
    rand_port(1, 1);
    exp_last = 1; grants = 0; rsps = 0;
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 600 && rsps < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (rsp0_valid || rsp1_valid) begin
        p = rsp1_valid ? 1 : 0;
        rsps++;
        total++;
        if (((p == 1) ? rsp1_data : rsp0_data) !== pend[p]) begin
          bad++; $display("FAIL alt_rsp%0d_data: got %h want %h", p,
                          (p == 1) ? rsp1_data : rsp0_data, pend[p]);
        end
      end
      if ((req0_ready || req1_ready) && grants < 4) begin
        g = exp_last ? 0 : 1;
        total++;
        if ({req1_ready, req0_ready} !== (2'b01 << g)) begin
          bad++; $display("FAIL alt_grant%0d: got %b want %b", grants, {req1_ready, req0_ready},
                          2'b01 << g);
        end
        pend[g] = pmul_ref(r_h[g], r_c[g], 5'b00100, r_a[g], r_b[g]);
        exp_last = g[0];
        grants++;
        @(posedge clock); #1;
        if (grants == 4) begin
          req0_valid = 0; req1_valid = 0;
        end else begin
          rand_port(g, 1);
        end
      end
    end
    total++;
    if (rsps != 4) begin
      bad++; $display("FAIL alt_rsp_count: got %0d want 4", rsps);
    end
  endtask

  task automatic test_basic;
    do_req(0, 1, 0, 0, 5'b00001, 32'h00010003, 32'h00000005, 32'h0005000F, 0, 0);
  endtask

  task automatic test_clmul;
    do_req(0, 1, 0, 1, 5'b00001, 32'h3, 32'h3, 32'h5, 0, 0);
  endtask

  task automatic test_illegal;
    do_req(1, 1, 0, 0, 5'b01000, 32'h1234, 32'h5678, 32'h0, 0, 0);
  endtask

  // Port 0 pw16 with response held; port 1 waits until the handshake completes
  task automatic test_hold;
    logic [31:0] a0, b0, a1, b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    drive(1, 0, 0, 1, 0, 5'b00010, a1, b1);
    do_req(0, 1, 0, 0, 5'b00010, a0, b0, pmul_ref(0, 0, 5'b00010, a0, b0), 10, 1);
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL hold_next_grant: req1_ready=%b want 1", req1_ready);
    end
    do_req(1, 0, 1, 0, 5'b00010, a1, b1, pmul_ref(1, 0, 5'b00010, a1, b1), 0, 0);
  endtask

  task automatic test_mid_reset;
    bit got;
    int stray;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    drive(0, 1, 1, 0, 0, 5'b00001, a, b);
    #1;
    got = req0_ready;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock); #1; got = req0_ready;
    end
    @(posedge clock); #1;
    req0_valid = 0;
    repeat (10) @(negedge clock);
    total++;
    if (mul_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_busy: mul_valid=%b want 1", mul_valid);
    end
    resetn = 0;
    @(negedge clock);
    resetn = 1;
    total++;
    if ({mul_valid, rsp0_valid, rsp1_valid} !== 3'b000 || mul_crs1 !== 32'h0) begin
      bad++; $display("FAIL midrst_idle: mul_valid/rsp0/rsp1=%b crs1=%h want 000 0",
                      {mul_valid, rsp0_valid, rsp1_valid}, mul_crs1);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mul_valid || rsp0_valid || rsp1_valid) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL midrst_stray: got %0d active cycles want 0", stray);
    end
    a = $urandom; b = $urandom;
    do_req(0, 0, 1, 0, 5'b00010, a, b, pmul_ref(1, 0, 5'b00010, a, b), 0, 0);
  endtask

  task automatic test_spurious;
    int stray;
    stray = 0;
    spur = 1;
    repeat (3) begin
      @(negedge clock);
      if (mul_valid || rsp0_valid || rsp1_valid) stray++;
    end
    spur = 0;
    repeat (2) begin
      @(negedge clock);
      if (mul_valid || rsp0_valid || rsp1_valid) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL spurious_ready: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_random;
    logic [4:0] pws [7];
    int port, s, hold;
    logic [4:0] pw;
    logic [31:0] a, b;
    pws = '{5'b00001, 5'b00010, 5'b00100, 5'b00000, 5'b00011, 5'b10001, 5'b00110};
    for (int n = 0; n < 12; n++) begin
      port = $urandom_range(0, 1);
      s    = $urandom_range(0, 2);
      pw   = ($urandom_range(0, 5) == 0) ? pws[$urandom_range(3, 6)] : pws[$urandom_range(0, 2)];
      hold = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      do_req(port, s == 0, s == 1, s == 2, pw, a, b, pmul_ref(s == 1, s == 2, pw, a, b), hold, 0);
    end
  endtask

  initial begin
    resetn = 0;
    drive(0, 0, 0, 0, 0, 5'b0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 0, 5'b0, 32'h0, 32'h0);
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) @(negedge clock);
    resetn = 1;
    test_reset();
    test_alternate();
    test_basic();
    test_clmul();
    test_illegal();
    test_hold();
    test_mid_reset();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
